keycode_report_decoder: RTL and testbench

Producer side of the keycode bus consumed by the player, harpoon and game-state logic. Accepts an 8-byte USB HID boot-keyboard report as a byte stream from the host-interface glue, validates and assembles it, and publishes `keycode`..`keycode4` plus modifiers atomically, so consumers never see a partially updated report. Sits between the USB/PIO bridge and every keycode consumer in the top level.

---
 rtl/keyboard_pkg.sv | 19 +
 rtl/keycode_promote.sv | 42 ++++
 rtl/keycode_report_decoder.sv | 150 +++++++++++++++
 tb/tb_keycode_report_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared types and constants for the HID boot-keyboard report decoder.
package keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam int         HID_REPORT_LEN   = 8;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_LEFT         = 8'h50;
  localparam logic [7:0] KEY_RIGHT        = 8'h4f;

  function automatic logic is_move_key(input logic [7:0] key);
    return (key == KEY_LEFT) || (key == KEY_RIGHT);
  endfunction

endpackage

// File: rtl/keycode_promote.sv
// Moves the first left/right arrow key of the six report slots into slot 0.
// Only instantiated when MOVE_KEY_PROMOTE_EN is defined.
module keycode_promote
  import keyboard_pkg::*;
(
  input  logic [47:0] i_slots,
  output logic [31:0] o_pub
);

  logic       w_found;
  logic [2:0] w_idx;

  // Scan high to low so the lowest-indexed movement key wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (is_move_key(i_slots[8*i +: 8])) begin
        w_found = 1'b1;
        w_idx   = 3'(i);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Slots 4..5 only matter as a swap source; the displaced slot-0 key lands there unseen.
  always_comb begin
    o_pub = i_slots[31:0];
    if (w_found) begin
      o_pub[7:0] = i_slots[{w_idx, 3'b000} +: 8];
      if (w_idx < 3'd4) begin
        o_pub[{w_idx[1:0], 3'b000} +: 8] = i_slots[7:0];
      end else begin
        o_pub = o_pub;
      end
    end else begin
      o_pub = i_slots[31:0];
    end
  end

endmodule

// File: rtl/keycode_report_decoder.sv
// Assembles 8-byte HID boot-keyboard reports and publishes keys atomically.
// Optional feature: define MOVE_KEY_PROMOTE_EN to promote arrow keys into keycode.
module keycode_report_decoder
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sop,
  output logic       in_ready,
  output logic [7:0] keycode,
  output logic [7:0] keycode2,
  output logic [7:0] keycode3,
  output logic [7:0] keycode4,
  output logic [7:0] modifiers,
  output logic       report_stb,
  output logic       rollover_err,
  output logic [7:0] drop_cnt
);

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_idx;
  logic [7:0]       r_mod;
  logic [47:0]      r_slots;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_pub;

  logic             r_in_ready;
  logic [31:0]      r_pub;
  logic [7:0]       r_modifiers;
  logic             r_report_stb;
  logic             r_rollover_err;
  logic [7:0]       r_drop_cnt;

  logic w_accept, w_timeout, w_restart, w_drop, w_rollover, w_last_byte;
  logic w_stb_next, w_err_next, w_ready_next;

  assign w_accept    = in_valid & r_in_ready;
  assign w_last_byte = (r_idx == 3'(HID_REPORT_LEN - 1));
  // An accepted byte always beats an expiring timer.
  assign w_timeout   = (r_state == ST_COLLECT) && !w_accept &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_restart   = (r_state == ST_COLLECT) && w_accept && in_sop;
  assign w_drop      = w_timeout || w_restart;
  assign w_rollover  = (r_slots == {6{KEY_ERR_ROLLOVER}});

`ifdef MOVE_KEY_PROMOTE_EN
  keycode_promote u_promote (
    .i_slots (r_slots),
    .o_pub   (w_pub)
  );
`else
  assign w_pub = r_slots[31:0];
`endif

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && in_sop) w_next_state = ST_COLLECT;
        else                    w_next_state = ST_IDLE;
      end
      ST_COLLECT: begin
        if (w_timeout)                              w_next_state = ST_IDLE;
        else if (w_accept && !in_sop && w_last_byte) w_next_state = ST_COMMIT;
        else                                        w_next_state = ST_COLLECT;
      end
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode feeding the registered outputs.
  always_comb begin
    w_ready_next = (w_next_state != ST_COMMIT);
    w_stb_next   = 1'b0;
    w_err_next   = 1'b0;
    if (r_state == ST_COMMIT) begin
      w_stb_next = !w_rollover;
      w_err_next = w_rollover;
    end else begin
      w_stb_next = 1'b0;
      w_err_next = 1'b0;
    end
  end

  // Byte capture and inter-byte timer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_idx   <= 3'd0;
      r_mod   <= 8'h00;
      r_slots <= 48'h0;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (w_accept && in_sop) begin
        r_mod <= in_data;
        r_idx <= 3'd1;
      end else if (w_accept && (r_state == ST_COLLECT)) begin
        if (r_idx >= 3'd2) r_slots[{r_idx - 3'd2, 3'b000} +: 8] <= in_data;
        r_idx <= r_idx + 3'd1;
      end
      if ((r_state == ST_COLLECT) && !w_accept) r_cnt <= r_cnt + CNT_W'(1);
      else                                     r_cnt <= {CNT_W{1'b0}};
    end
  end

  // Published outputs, strobes and drop counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_in_ready     <= 1'b1;
      r_pub          <= 32'h0;
      r_modifiers    <= 8'h00;
      r_report_stb   <= 1'b0;
      r_rollover_err <= 1'b0;
      r_drop_cnt     <= 8'h00;
    end else begin
      r_in_ready     <= w_ready_next;
      r_report_stb   <= w_stb_next;
      r_rollover_err <= w_err_next;
      if (w_stb_next) begin
        r_pub       <= w_pub;
        r_modifiers <= r_mod;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign in_ready     = r_in_ready;
  assign keycode      = r_pub[7:0];
  assign keycode2     = r_pub[15:8];
  assign keycode3     = r_pub[23:16];
  assign keycode4     = r_pub[31:24];
  assign modifiers    = r_modifiers;
  assign report_stb   = r_report_stb;
  assign rollover_err = r_rollover_err;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_keycode_report_decoder.sv
// Directed plus randomized bench for keycode_report_decoder with a report-level model.
module tb_keycode_report_decoder;

  localparam int T  = 40;
  localparam int CW = 8;

  logic       Clk, Reset, in_valid, in_sop, in_ready;
  logic [7:0] in_data, keycode, keycode2, keycode3, keycode4, modifiers, drop_cnt;
  logic       report_stb, rollover_err;

  int vectors     = 0;
  int miscompares = 0;
  int stb_seen    = 0;
  int err_seen    = 0;

  logic [7:0] exp_kc [4];
  logic [7:0] exp_mod, exp_drop;
  logic       exp_stb, exp_err;
  logic [7:0] rep [8];

  keycode_report_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
    .in_ready(in_ready), .keycode(keycode), .keycode2(keycode2), .keycode3(keycode3),
    .keycode4(keycode4), .modifiers(modifiers), .report_stb(report_stb),
    .rollover_err(rollover_err), .drop_cnt(drop_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (report_stb)   stb_seen++;
    if (rollover_err) err_seen++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    int n = 0;
    @(negedge Clk);
    in_valid = 1'b1; in_data = d; in_sop = s;
    while (!in_ready && n < 8) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 8) chk("ready_wait", 8'(in_ready), 8'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  // Report-level model: what a consumer should see once a full report lands.
  function automatic void model_report(input logic [7:0] r [8]);
    logic [7:0] k [6];
    bit all_err = 1'b1;
    for (int i = 0; i < 6; i++) begin
      k[i] = r[i+2];
      if (k[i] != 8'h01) all_err = 1'b0;
    end
    if (all_err) begin
      exp_stb = 1'b0; exp_err = 1'b1;
      return;
    end
`ifdef MOVE_KEY_PROMOTE_EN
    for (int i = 0; i < 6; i++) begin
      if (k[i] == 8'h50 || k[i] == 8'h4f) begin
        logic [7:0] t0;
        t0 = k[0]; k[0] = k[i]; k[i] = t0;
        break;
      end
    end
`endif
    for (int i = 0; i < 4; i++) exp_kc[i] = k[i];
    exp_mod = r[0];
    exp_stb = 1'b1; exp_err = 1'b0;
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, "_kc1"}, keycode,   exp_kc[0]);
    chk({pfx, "_kc2"}, keycode2,  exp_kc[1]);
    chk({pfx, "_kc3"}, keycode3,  exp_kc[2]);
    chk({pfx, "_kc4"}, keycode4,  exp_kc[3]);
    chk({pfx, "_mod"}, modifiers, exp_mod);
    chk({pfx, "_drop"}, drop_cnt, exp_drop);
  endtask

  task automatic check_commit();
    @(negedge Clk);
    chk("commit_ready_low", 8'(in_ready), 8'd0);
    chk("commit_stb_early", 8'(report_stb), 8'd0);
    @(negedge Clk);
    chk("stb", 8'(report_stb), 8'(exp_stb));
    chk("rollover", 8'(rollover_err), 8'(exp_err));
    chk("ready_back", 8'(in_ready), 8'd1);
    check_outputs("pub");
    @(negedge Clk);
    chk("stb_end", 8'(report_stb), 8'd0);
    chk("rollover_end", 8'(rollover_err), 8'd0);
  endtask

  task automatic send_report(input logic [7:0] r [8], input int max_gap);
    for (int i = 0; i < 8; i++) begin
      send_byte(r[i], (i == 0));
      if (i < 7 && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
    end
    model_report(r);
    check_commit();
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(9, 0))
      0:       return 8'h50;
      1:       return 8'h4f;
      2, 3:    return 8'h00;
      default: return 8'($urandom_range(32'h30, 32'h04));
    endcase
  endfunction

  initial begin
    int s0, e0;
    Reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 4; i++) exp_kc[i] = 8'h00;
    exp_mod = 8'h00; exp_drop = 8'h00;

    @(negedge Clk);
    chk("rst_ready", 8'(in_ready), 8'd1);
    chk("rst_stb", 8'(report_stb), 8'd0);
    chk("rst_err", 8'(rollover_err), 8'd0);
    check_outputs("rst");
    @(negedge Clk);
    Reset = 1'b0;

    // Basic key press, back-to-back bytes.
    s0 = stb_seen;
    rep = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(rep, 0);
    chk("one_stb", 8'(stb_seen - s0), 8'd1);

    // Phantom-state report keeps the previous keys.
    s0 = stb_seen; e0 = err_seen;
    rep = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_report(rep, 0);
    chk("roll_no_stb", 8'(stb_seen - s0), 8'd0);
    chk("roll_one_err", 8'(err_seen - e0), 8'd1);

    // Partial report interrupted by a new start byte.
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    exp_drop = exp_drop + 8'd1;
    rep = '{8'h02, 8'h00, 8'h4f, 8'h1d, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(rep, 0);

    // Inter-byte timeout, then a stray byte that must be ignored.
    send_byte(8'h33, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h09, 1'b0);
    idle(T - 2);
    chk("to_not_yet", drop_cnt, exp_drop);
    idle(3);
    exp_drop = exp_drop + 8'd1;
    chk("to_drop", drop_cnt, exp_drop);
    s0 = stb_seen;
    send_byte(8'h07, 1'b0);
    idle(12);
    chk("to_no_stb", 8'(stb_seen - s0), 8'd0);
    check_outputs("to_hold");

    // Arrow key in the last slot.
    rep = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h50};
    send_report(rep, 0);

    // Randomized reports with gaps and stray non-start bytes.
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(2, 0)) send_byte(8'($urandom), 1'b0);
      rep[0] = 8'($urandom);
      rep[1] = 8'($urandom);
      for (int i = 2; i < 8; i++) rep[i] = rand_key();
      if ($urandom_range(7, 0) == 0)
        for (int i = 2; i < 8; i++) rep[i] = 8'h01;
      send_report(rep, 3);
    end

    // Asynchronous reset in the middle of a report.
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h2a, 1'b0);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_kc[i] = 8'h00;
    exp_mod = 8'h00; exp_drop = 8'h00;
    chk("arst_ready", 8'(in_ready), 8'd1);
    check_outputs("arst");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    rep = '{8'h40, 8'h00, 8'h2c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(rep, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
